// File: rtl/sd_pkg.sv
// Shared types and constants for the SD sector writer: default sector size,
// counter widths, FSM state encoding and the byte sent when the source runs dry.
package sd_pkg;

  localparam int unsigned SECTOR_BYTES_DEF = 512;
  localparam int unsigned BYTE_CNT_W       = 10;
  localparam int unsigned SECTOR_IDX_W     = 16;
  localparam logic [7:0]  UNDERRUN_PAD     = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_ISSUE,
    S_STREAM,
    S_DRAIN,
    S_NEXT,
    S_FAIL
  } state_t;

endpackage

// File: rtl/sd_byte_stage.sv
// One-byte holding register between the source stream and the SD controller.
// Refills in the same cycle the controller consumes, so streaming has no bubbles.
module sd_byte_stage
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       fill_en,
  input  logic       consume,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] hold_data,
  output logic       hold_full
);

  assign in_ready = fill_en && (!hold_full || consume);

  // An emptied register reads as the pad byte so an underrun sends 0x00.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= UNDERRUN_PAD;
    end else if (in_valid && in_ready) begin
      hold_full <= 1'b1;
      hold_data <= in_data;
    end else if (consume) begin
      hold_full <= 1'b0;
      hold_data <= UNDERRUN_PAD;
    end
  end

endmodule

// File: rtl/sd_sector_writer.sv
// Streams a byte source into consecutive SD sectors through a write controller.
// Optional sd_ready watchdog: define SD_SECTOR_WRITER_TIMEOUT_EN.
module sd_sector_writer
  import sd_pkg::*;
#(
  parameter int unsigned SECTOR_BYTES   = SECTOR_BYTES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 16777216
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] num_sectors,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        sd_wr,
  output logic [7:0]  sd_din,
  output logic [31:0] sd_addr,
  input  logic        sd_ready,
  input  logic        sd_ready_for_next_byte,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic        error
);

  localparam logic [BYTE_CNT_W-1:0] BYTE_LAST     = BYTE_CNT_W'(SECTOR_BYTES - 1);
  localparam logic [31:0]           SECTOR_STRIDE = 32'(SECTOR_BYTES);

  if (SECTOR_BYTES < 2 || SECTOR_BYTES >= (1 << BYTE_CNT_W) || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("sd_sector_writer: unsupported SECTOR_BYTES or TIMEOUT_CYCLES");
  end

  state_t                  state;
  logic [SECTOR_IDX_W-1:0] sector_idx;
  logic [SECTOR_IDX_W-1:0] num_lat;
  logic [BYTE_CNT_W-1:0]   byte_cnt;
  logic                    hold_full;
  logic                    consume;
  logic                    last_byte;
  logic                    last_sector;
  logic                    fill_en;

  assign consume     = (state == S_STREAM) && sd_ready_for_next_byte;
  assign last_byte   = (byte_cnt == BYTE_LAST);
  assign last_sector = (sector_idx == num_lat - SECTOR_IDX_W'(1));

  // Prefetch before streaming; never pull a byte past the end of the transfer.
  assign fill_en = !reset && ((state == S_WAIT_RDY) || (state == S_ISSUE) ||
                   ((state == S_STREAM) && !(consume && last_byte && last_sector)));

  sd_byte_stage u_stage (
    .clk       (clk_25mhz),
    .reset     (reset),
    .fill_en   (fill_en),
    .consume   (consume),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .hold_data (sd_din),
    .hold_full (hold_full)
  );

`ifdef SD_SECTOR_WRITER_TIMEOUT_EN
  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_run;
  logic             tmo_leave;
  logic             tmo_hit;
  logic             error_q;

  assign tmo_run   = state inside {S_WAIT_RDY, S_ISSUE, S_DRAIN};
  assign tmo_leave = ((state == S_WAIT_RDY) || (state == S_DRAIN)) ? sd_ready
                                                                   : ((state == S_ISSUE) && !sd_ready);
  assign tmo_hit   = tmo_run && !tmo_leave && (tmo_cnt == TMO_LAST);

  // Watchdog restarts on every state change.
  always_ff @(posedge clk_25mhz) begin
    if (reset || !tmo_run || tmo_leave) tmo_cnt <= '0;
    else                                tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state      <= S_IDLE;
      sector_idx <= '0;
      num_lat    <= '0;
      byte_cnt   <= '0;
      sd_wr      <= 1'b0;
      sd_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
`ifdef SD_SECTOR_WRITER_TIMEOUT_EN
      error_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (consume && !hold_full) underrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            underrun <= 1'b0;
            if (num_sectors != '0) begin
              num_lat    <= num_sectors;
              sector_idx <= '0;
              sd_addr    <= base_addr;
              busy       <= 1'b1;
              state      <= S_WAIT_RDY;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_WAIT_RDY: begin
          if (sd_ready) begin
            sd_wr <= 1'b1;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!sd_ready) begin
            sd_wr    <= 1'b0;
            byte_cnt <= '0;
            state    <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (consume) begin
            byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
            if (last_byte) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (sd_ready) state <= S_NEXT;
        end
        S_NEXT: begin
          sector_idx <= sector_idx + SECTOR_IDX_W'(1);
          if (last_sector) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            sd_addr <= sd_addr + SECTOR_STRIDE;
            state   <= S_WAIT_RDY;
          end
        end
        default: begin
          sd_wr <= 1'b0;
          busy  <= 1'b0;
        end
      endcase

`ifdef SD_SECTOR_WRITER_TIMEOUT_EN
      if (tmo_hit) begin
        state   <= S_FAIL;
        sd_wr   <= 1'b0;
        busy    <= 1'b0;
        error_q <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sd_sector_writer.sv
// Directed bench for sd_sector_writer: table of transfers against a behavioural
// SD controller and byte source, plus hand sequences for reset and zero-length cases.
`timescale 1ns/1ps
module tb_sd_sector_writer;

  localparam int SB = 512;
  localparam int C_IDLE = 0, C_PRE = 1, C_STR = 2, C_POST = 3;

  logic        clk_25mhz = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_sectors = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sd_wr;
  logic [7:0]  sd_din;
  logic [31:0] sd_addr;
  logic        sd_ready = 1'b1;
  logic        sd_ready_for_next_byte = 1'b0;
  logic        busy, done, underrun, error;

  int tests = 0;
  int fails = 0;

  sd_sector_writer #(.SECTOR_BYTES(SB), .TIMEOUT_CYCLES(64)) dut (
    .clk_25mhz              (clk_25mhz),
    .reset                  (reset),
    .start                  (start),
    .base_addr              (base_addr),
    .num_sectors            (num_sectors),
    .in_data                (in_data),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .sd_wr                  (sd_wr),
    .sd_din                 (sd_din),
    .sd_addr                (sd_addr),
    .sd_ready               (sd_ready),
    .sd_ready_for_next_byte (sd_ready_for_next_byte),
    .busy                   (busy),
    .done                   (done),
    .underrun               (underrun),
    .error                  (error)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  typedef struct {
    logic [31:0] base;
    logic [15:0] num;
    bit          gap;
    int          z_lo;
    int          z_hi;
    bit          poke;
    logic [31:0] addr0;
    logic [31:0] addr_last;
    int          wrs;
    int          accepted;
    logic        underrun;
  } vec_t;

  vec_t vecs[6];

  // Environment state shared by the controller/source model and the checks.
  int          ctl = C_IDLE;
  int          ctl_wait = 0;
  bit          phase = 1'b0;
  int          pc = 0;
  int          src_idx = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;
  bit          src_en = 1'b0;
  bit          gap_on = 1'b0;
  int          z_lo = 0;
  int          z_hi = 0;
  bit          hold_busy = 1'b0;
  logic [7:0]  cap_q[$];
  logic [31:0] addr_q[$];

  function automatic logic [7:0] src_byte(input int k);
    return 8'((k * 37 + 11) & 255);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural SD controller and byte source, stepped once per cycle.
  initial begin
    forever begin
      @(negedge clk_25mhz);
      if (reset) begin
        ctl = C_IDLE;
        sd_ready = 1'b1;
        sd_ready_for_next_byte = 1'b0;
      end else begin
        case (ctl)
          C_IDLE: begin
            sd_ready = 1'b1;
            sd_ready_for_next_byte = 1'b0;
            if (sd_wr) begin
              addr_q.push_back(sd_addr);
              wr_cnt++;
              sd_ready = 1'b0;
              ctl = C_PRE;
              ctl_wait = 2;
              pc = 0;
            end
          end
          C_PRE: begin
            sd_ready_for_next_byte = 1'b0;
            if (ctl_wait == 0) begin
              ctl = C_STR;
              phase = 1'b1;
            end else ctl_wait--;
          end
          C_STR: begin
            sd_ready_for_next_byte = phase;
            phase = !phase;
          end
          default: begin
            sd_ready_for_next_byte = 1'b0;
            if (ctl_wait == 0) begin
              ctl = C_IDLE;
              sd_ready = 1'b1;
            end else ctl_wait--;
          end
        endcase
      end
      if (hold_busy) sd_ready = 1'b0;
      in_valid = src_en && !(gap_on && pc >= z_lo - 1 && pc <= z_hi);
      in_data  = src_byte(src_idx);
      #1;
      if (in_valid && in_ready) src_idx++;
      if (sd_ready_for_next_byte) begin
        cap_q.push_back(sd_din);
        pc++;
        if (pc == SB) begin
          ctl = C_POST;
          ctl_wait = 3;
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_case(input int i);
    vec_t       v;
    int         budget;
    bit         poked;
    int         k;
    int         bad;
    int         pos;
    logic [7:0] e;
    v = vecs[i];
    poked = 1'b0;
    @(negedge clk_25mhz);
    cap_q.delete();
    addr_q.delete();
    src_idx = 0;
    done_cnt = 0;
    wr_cnt = 0;
    gap_on = v.gap;
    z_lo = v.z_lo;
    z_hi = v.z_hi;
    src_en = 1'b1;
    base_addr = v.base;
    num_sectors = v.num;
    start = 1'b1;
    @(negedge clk_25mhz);
    start = 1'b0;
    budget = 1200 * int'(v.num) + 40;
    while (done_cnt == 0 && budget > 0) begin
      @(negedge clk_25mhz);
      budget--;
      if (v.poke && !poked && cap_q.size() >= 700) begin
        base_addr = 32'hDEAD_0000;
        num_sectors = 16'd7;
        start = 1'b1;
        poked = 1'b1;
      end else start = 1'b0;
    end
    start = 1'b0;
    check($sformatf("case%0d_done_seen", i), 32'(done_cnt > 0), 32'd1);
    repeat (6) @(negedge clk_25mhz);
    #2;
    check($sformatf("case%0d_done_count", i), 32'(done_cnt), 32'd1);
    check($sformatf("case%0d_wr_count", i), 32'(wr_cnt), 32'(v.wrs));
    if (v.wrs > 0) begin
      if (addr_q.size() > 0) begin
        check($sformatf("case%0d_addr_first", i), addr_q[0], v.addr0);
        check($sformatf("case%0d_addr_last", i), addr_q[addr_q.size() - 1], v.addr_last);
      end else check($sformatf("case%0d_addr_seen", i), 32'd0, 32'd1);
    end
    check($sformatf("case%0d_byte_count", i), 32'(cap_q.size()), 32'(v.wrs * SB));
    k = 0;
    bad = 0;
    foreach (cap_q[j]) begin
      pos = j % SB;
      if (v.gap && pos >= v.z_lo && pos <= v.z_hi) e = 8'h00;
      else begin
        e = src_byte(k);
        k++;
      end
      if (cap_q[j] !== e) bad++;
    end
    check($sformatf("case%0d_data_errors", i), 32'(bad), 32'd0);
    check($sformatf("case%0d_accepted", i), 32'(src_idx), 32'(v.accepted));
    check($sformatf("case%0d_underrun", i), 32'(underrun), 32'(v.underrun));
    check($sformatf("case%0d_busy_end", i), 32'(busy), 32'd0);
    check($sformatf("case%0d_sd_wr_end", i), 32'(sd_wr), 32'd0);
    check($sformatf("case%0d_error", i), 32'(error), 32'd0);
    src_en = 1'b0;
  endtask

  initial begin
    int wr_before;
    int budget;
    //           base          num  gap z_lo z_hi poke addr0         addr_last     wrs acc   urun
    vecs[0] = '{32'h0000_0400, 16'd1, 1'b0, 0,   0,   1'b0, 32'h0000_0400, 32'h0000_0400, 1, 512,  1'b0};
    vecs[1] = '{32'h0000_0000, 16'd3, 1'b0, 0,   0,   1'b1, 32'h0000_0000, 32'h0000_0400, 3, 1536, 1'b0};
    vecs[2] = '{32'h0000_1000, 16'd1, 1'b1, 100, 109, 1'b0, 32'h0000_1000, 32'h0000_1000, 1, 502,  1'b1};
    vecs[3] = '{32'hFFFF_FE00, 16'd2, 1'b0, 0,   0,   1'b0, 32'hFFFF_FE00, 32'h0000_0000, 2, 1024, 1'b0};
    vecs[4] = '{32'h0000_0800, 16'd0, 1'b0, 0,   0,   1'b0, 32'h0000_0000, 32'h0000_0000, 0, 0,    1'b0};
    vecs[5] = '{32'h0000_6000, 16'd1, 1'b0, 0,   0,   1'b0, 32'h0000_6000, 32'h0000_6000, 1, 512,  1'b0};

    // Reset behaviour, with the source offering data throughout.
    src_en = 1'b1;
    repeat (3) @(negedge clk_25mhz);
    #2;
    check("in_ready_during_reset", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk_25mhz);
    #2;
    check("reset_sd_wr", 32'(sd_wr), 32'd0);
    check("reset_sd_din", 32'(sd_din), 32'd0);
    check("reset_sd_addr", sd_addr, 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_underrun", 32'(underrun), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("idle_no_accept", 32'(src_idx), 32'd0);
    src_en = 1'b0;

    for (int i = 0; i < 4; i++) run_case(i);

    // Zero-length transfer: done exactly one cycle after start, no write.
    @(negedge clk_25mhz);
    wr_before = wr_cnt;
    base_addr = 32'h0000_0800;
    num_sectors = 16'd0;
    start = 1'b1;
    @(negedge clk_25mhz);
    start = 1'b0;
    #2;
    check("zero_done_pulse", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    @(negedge clk_25mhz);
    #2;
    check("zero_done_clear", 32'(done), 32'd0);
    repeat (10) @(negedge clk_25mhz);
    check("zero_no_sd_wr", 32'(wr_cnt), 32'(wr_before));

    run_case(4);

    // Reset in the middle of a sector abandons it.
    @(negedge clk_25mhz);
    cap_q.delete();
    src_idx = 0;
    gap_on = 1'b0;
    src_en = 1'b1;
    base_addr = 32'h0000_2000;
    num_sectors = 16'd2;
    start = 1'b1;
    @(negedge clk_25mhz);
    start = 1'b0;
    budget = 1500;
    while (cap_q.size() < 300 && budget > 0) begin
      @(negedge clk_25mhz);
      budget--;
    end
    check("midreset_reached_byte300", 32'(cap_q.size() >= 300), 32'd1);
    reset = 1'b1;
    @(negedge clk_25mhz);
    #2;
    check("midreset_sd_wr", 32'(sd_wr), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd0);
    check("midreset_sd_addr", sd_addr, 32'd0);
    check("midreset_sd_din", 32'(sd_din), 32'd0);
    reset = 1'b0;
    src_en = 1'b0;
    wr_before = wr_cnt;
    repeat (30) @(negedge clk_25mhz);
    check("midreset_no_new_wr", 32'(wr_cnt), 32'(wr_before));
    check("midreset_idle_busy", 32'(busy), 32'd0);

    run_case(5);

`ifdef SD_SECTOR_WRITER_TIMEOUT_EN
    // Watchdog: controller never becomes ready.
    hold_busy = 1'b1;
    @(negedge clk_25mhz);
    base_addr = 32'h0;
    num_sectors = 16'd1;
    start = 1'b1;
    @(negedge clk_25mhz);
    start = 1'b0;
    repeat (60) @(negedge clk_25mhz);
    #2;
    check("tmo_error_before", 32'(error), 32'd0);
    check("tmo_busy_before", 32'(busy), 32'd1);
    repeat (10) @(negedge clk_25mhz);
    #2;
    check("tmo_error_set", 32'(error), 32'd1);
    check("tmo_busy_fail", 32'(busy), 32'd0);
    check("tmo_sd_wr_fail", 32'(sd_wr), 32'd0);
    check("tmo_in_ready_fail", 32'(in_ready), 32'd0);
    hold_busy = 1'b0;
    repeat (5) @(negedge clk_25mhz);
    #2;
    check("tmo_error_sticky", 32'(error), 32'd1);
    check("tmo_stays_fail", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clk_25mhz);
    reset = 1'b0;
    @(negedge clk_25mhz);
    #2;
    check("tmo_error_cleared", 32'(error), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1);
  end

endmodule

// File: doc/sd_sector_writer.md
SD_SECTOR_WRITER -- requirements
Module: sd_sector_writer

Interface
REQ-001 Parameter SECTOR_BYTES, default 512: bytes per sector.
REQ-002 Parameter TIMEOUT_CYCLES, default 16777216: sd_ready watchdog limit.
REQ-003 clk_25mhz  in  1  sole clock, same clock as the SD controller.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 start  in  1  one-cycle pulse; begins a transfer; accepted only in IDLE.
REQ-006 base_addr  in  32  byte address of first sector; multiple of SECTOR_BYTES.
REQ-007 num_sectors  in  16  sectors to write; 0 means none.
REQ-008 in_data / in_valid / in_ready  in/in/out  8/1/1  source byte stream; a byte transfers when in_valid and in_ready are both high.
REQ-009 sd_wr  out  1  write request to the SD controller.
REQ-010 sd_din  out  8  byte presented to the SD controller.
REQ-011 sd_addr  out  32  sector byte address to the SD controller.
REQ-012 sd_ready / sd_ready_for_next_byte  in/in  1/1  controller idle; controller consumed sd_din (one-cycle pulse).
REQ-013 busy / done / underrun / error  out  1 each  status: done is a one-cycle pulse; underrun and error are sticky.

Function
REQ-014 States: IDLE, WAIT_RDY, ISSUE, STREAM, DRAIN, NEXT, FAIL.
REQ-015 IDLE: start with num_sectors>0 latches base_addr/num_sectors -> WAIT_RDY; start with num_sectors=0 pulses done the next cycle and stays in IDLE.
REQ-016 WAIT_RDY: sd_ready high -> ISSUE; sd_addr = base_addr + sector_idx*SECTOR_BYTES, held stable until NEXT.
REQ-017 ISSUE: sd_wr held high until sd_ready falls, then -> STREAM with sd_wr low.
REQ-018 One-byte holding register feeds sd_din; in_ready = holding empty OR sd_ready_for_next_byte this cycle (full throughput, no bubble).
REQ-019 Each sd_ready_for_next_byte pulse in STREAM increments byte_cnt; holding register empties unless refilled the same cycle.
REQ-020 Pulse while the holding register is empty: sd_din = 8'h00, underrun set, byte still counted; the stream is not stalled.
REQ-021 byte_cnt reaching SECTOR_BYTES -> DRAIN; in_ready low in DRAIN; a held byte stays for the next sector.
REQ-022 DRAIN: sd_ready high -> NEXT; NEXT increments sector_idx; if sector_idx = num_sectors, pulse done and go to IDLE, else -> WAIT_RDY.
REQ-023 busy high in every state except IDLE and FAIL.
REQ-024 start outside IDLE is ignored; extra sd_ready_for_next_byte pulses outside STREAM are ignored.
REQ-025 sector_idx arithmetic 16-bit and byte_cnt 10-bit; sd_addr wraps modulo 2^32 with no error.
REQ-026 underrun clears on the next accepted start; error clears only on reset.

Reset
REQ-027 reset forces IDLE, clears the holding register, byte_cnt, sector_idx, underrun and error.
REQ-028 Outputs during and after reset: sd_wr=0, sd_din=0, sd_addr=0, in_ready=0, busy=0, done=0.
REQ-029 Reset mid-sector abandons the sector; no further sd_wr is issued until a new start.

Configuration
REQ-030 Macro SD_SECTOR_WRITER_TIMEOUT_EN defined: a cycle counter runs in WAIT_RDY, ISSUE and DRAIN, is cleared on every state change, and at TIMEOUT_CYCLES sets error and moves to FAIL.
REQ-031 FAIL holds sd_wr=0 and in_ready=0 until reset.
REQ-032 Macro undefined: no counter is built, FAIL is unreachable, error is tied to 0.

Structure
REQ-033 Shared package sd_pkg holds the SECTOR_BYTES default, the state encoding, and the 8'h00 underrun pad constant.
REQ-034 Holding register and in_ready logic form one sub-module, sd_byte_stage; the FSM and counters stay in sd_sector_writer.

Verification
REQ-035 num_sectors=1, base_addr=0x400, source always valid: sd_addr=0x400, 512 bytes in source order, done exactly once, underrun=0.
REQ-036 num_sectors=3, base_addr=0: sd_addr steps 0x000, 0x200, 0x400; 1536 bytes delivered with no byte lost across sector boundaries.
REQ-037 in_valid low for bytes 100-109 of a sector: those ten bytes are written as 0x00, underrun=1, sector still completes and done pulses.
REQ-038 reset asserted at byte 300: next cycle sd_wr=0, busy=0, in_ready=0; a new start restarts from the new base_addr.
REQ-039 With SD_SECTOR_WRITER_TIMEOUT_EN and TIMEOUT_CYCLES=64, sd_ready held low: error=1 at cycle 64 of WAIT_RDY, state FAIL until reset.
REQ-040 start with num_sectors=0: done pulses one cycle later, sd_wr never asserts.
